// File: rtl/zigzag_pkg.sv
// Shared definitions for the zig-zag scan engine: sample count, mode and
// state encodings, and the JPEG 8x8 zig-zag table.
package zigzag_pkg;

    localparam int NUM_SAMPLES = 64;

    localparam logic [1:0] MODE_FWD = 2'd0;
    localparam logic [1:0] MODE_INV = 2'd1;
    localparam logic [1:0] MODE_BYP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Entry k is the raster position of the k-th coefficient in zig-zag order.
    localparam logic [5:0] ZZ_TABLE [NUM_SAMPLES] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_index(input logic [5:0] k);
        return ZZ_TABLE[k];
    endfunction

endpackage

// File: rtl/zigzag_index_map.sv
// Per-lane slot mapper: turns scan position k into the input slot read and
// the scan buffer slot written for the latched mode.
module zigzag_index_map
    import zigzag_pkg::*;
(
    input  logic [5:0] k,
    input  logic [1:0] mode,
    output logic [5:0] src,
    output logic [5:0] dst
);

    // Forward gathers through the table, inverse scatters through it,
    // bypass (and the unused encoding 3) is a straight copy.
    always_comb begin
        src = k;
        dst = k;
        case (mode)
            MODE_FWD: src = zz_index(k);
            MODE_INV: dst = zz_index(k);
            MODE_BYP: ;
            default:  ;
        endcase
    end

endmodule

// File: rtl/zigzag_scan_engine.sv
// Zig-zag / de-zig-zag / bypass reorderer for 8x8 coefficient blocks with a
// one-block input buffer, LANES-wide scan and a held output register.
module zigzag_scan_engine
    import zigzag_pkg::*;
#(
    parameter int COEFF_W = 16,
    parameter int LANES   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [1:0]                     mode,
    input  logic [NUM_SAMPLES*COEFF_W-1:0] block_in,
    input  logic                           block_valid,
    output logic                           block_ready,
    output logic [NUM_SAMPLES*COEFF_W-1:0] block_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [6:0]                     eob,
    output logic                           done,
    output logic                           busy
);

    localparam int         BEATS     = NUM_SAMPLES / LANES;
    localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);

    logic [COEFF_W-1:0] in_buf   [NUM_SAMPLES];
    logic [COEFF_W-1:0] scan_buf [NUM_SAMPLES];
    logic               in_full;
    state_t             state, state_next;
    logic [5:0]         scan_idx;
    logic [1:0]         mode_q;
    logic [6:0]         eob_acc, beat_eob;
    logic [5:0]         src_idx [LANES];
    logic [5:0]         dst_idx [LANES];
    logic               accept, start, beat, last_beat, commit;

    assign block_ready = !in_full && enable && rst;
    assign accept      = block_valid && block_ready;
    assign busy        = (state != ST_IDLE) || in_full;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [5:0] k;
        assign k = scan_idx * 6'(LANES) + 6'(l);
        zigzag_index_map u_map (
            .k    (k),
            .mode (mode_q),
            .src  (src_idx[l]),
            .dst  (dst_idx[l])
        );
    end

    // Fold this beat's nonzero destination slots into the running EOB.
    always_comb begin
        beat_eob = eob_acc;
        for (int l = 0; l < LANES; l++) begin
            if (in_buf[src_idx[l]] != '0 && ({1'b0, dst_idx[l]} + 7'd1) > beat_eob)
                beat_eob = {1'b0, dst_idx[l]} + 7'd1;
        end
    end

    // Next-state and strobes; enable=0 holds every state.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && in_full) begin
                    start      = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (enable) begin
                    beat = 1'b1;
                    if (scan_idx == LAST_BEAT) begin
                        last_beat  = 1'b1;
                        state_next = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (enable && (!out_valid || out_ready)) begin
                    commit = 1'b1;
                    // A block landing in in_buf on this very edge is started
                    // straight away so a steady stream needs no idle cycle.
                    if (in_full || accept) begin
                        start      = 1'b1;
                        state_next = ST_SCAN;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Control registers: FSM, buffer occupancy, scan counter, output handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            in_full   <= 1'b0;
            scan_idx  <= '0;
            mode_q    <= MODE_FWD;
            eob_acc   <= '0;
            eob       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= commit;
            if (accept)
                in_full <= 1'b1;
            else if (last_beat)
                in_full <= 1'b0;
            if (start) begin
                mode_q   <= mode;
                scan_idx <= '0;
                eob_acc  <= '0;
            end else if (beat) begin
                scan_idx <= scan_idx + 6'd1;
                eob_acc  <= beat_eob;
            end
            if (commit) begin
                out_valid <= 1'b1;
                eob       <= eob_acc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Output data register, loaded only on commit so it is stable while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            block_out <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_SAMPLES; i++)
                block_out[i*COEFF_W +: COEFF_W] <= scan_buf[i];
        end
    end

    // Input capture and lane-parallel permutation into the scan buffer.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_SAMPLES; i++)
                in_buf[i] <= block_in[i*COEFF_W +: COEFF_W];
        end
        if (start) begin
            for (int i = 0; i < NUM_SAMPLES; i++)
                scan_buf[i] <= '0;
        end else if (beat) begin
            for (int l = 0; l < LANES; l++)
                scan_buf[dst_idx[l]] <= in_buf[src_idx[l]];
        end
    end

endmodule

// File: tb/tb_zigzag_scan_engine.sv
// Directed bench for zigzag_scan_engine: one LANES=1 and one LANES=8 instance
// sharing control inputs, each with its own block_valid.
`timescale 1ns/1ps
module tb_zigzag_scan_engine;

    localparam int W  = 16;
    localparam int BW = 64 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [BW-1:0] block_in = '0;
    logic          out_ready = 1'b1;
    logic          bv1 = 1'b0, bv8 = 1'b0;
    logic          br1, ov1, done1, busy1;
    logic          br8, ov8, done8, busy8;
    logic [BW-1:0] bo1, bo8;
    logic [6:0]    eob1, eob8;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    logic [BW-1:0] fwd_res;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zigzag_scan_engine #(.COEFF_W(W), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .block_in(block_in), .block_valid(bv1), .block_ready(br1),
        .block_out(bo1), .out_valid(ov1), .out_ready(out_ready),
        .eob(eob1), .done(done1), .busy(busy1)
    );

    zigzag_scan_engine #(.COEFF_W(W), .LANES(8)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .block_in(block_in), .block_valid(bv8), .block_ready(br8),
        .block_out(bo8), .out_valid(ov8), .out_ready(out_ready),
        .eob(eob8), .done(done8), .busy(busy8)
    );

    function automatic logic [BW-1:0] ramp(input int off);
        logic [BW-1:0] r;
        for (int i = 0; i < 64; i++) r[i*W +: W] = W'(i + off);
        return r;
    endfunction

    function automatic logic [W-1:0] slot(input logic [BW-1:0] b, input int i);
        return b[i*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block until accepted (bounded); acc is the cycle of the accepting edge.
    task automatic offer(input bit lane8, input logic [BW-1:0] blk, input logic [1:0] md,
                         output int acc, output bit ok);
        block_in = blk;
        mode = md;
        ok = 1'b0;
        acc = 0;
        if (lane8) bv8 = 1'b1; else bv1 = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (lane8 ? br8 : br1) ok = 1'b1;
            tick();
            if (ok) acc = cyc;
        end
        bv1 = 1'b0;
        bv8 = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat=-1 on timeout; counts done pulses seen.
    task automatic wait_out(input bit lane8, input int acc, output int lat, output int dones);
        lat = -1;
        dones = 0;
        for (int i = 0; i < 300 && lat < 0; i++) begin
            tick();
            if (lane8 ? done8 : done1) dones++;
            if (lane8 ? ov8 : ov1) lat = cyc - acc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", ov1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done1); end
        checks++; if (eob1 !== 7'd0) begin errors++; $display("FAIL reset_eob got=%0d want=0", eob1); end
        checks++; if (bo1 !== '0) begin errors++; $display("FAIL reset_block_out got=nonzero want=0"); end
        checks++; if (br1 !== 1'b0) begin errors++; $display("FAIL reset_block_ready got=%b want=0", br1); end
        checks++; if (ov8 !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_lanes8 got=%b%b want=00", ov8, busy8); end
        rst = 1'b1;
        #1;
        checks++; if (br1 !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b want=1", br1); end
    endtask

    task automatic test_forward();
        int acc, lat, dones;
        bit ok;
        out_ready = 1'b1;
        offer(1'b0, ramp(0), 2'd0, acc, ok);
        wait_out(1'b0, acc, lat, dones);
        checks++; if (lat != 66) begin errors++; $display("FAIL fwd_latency got=%0d want=66", lat); end
        checks++; if (slot(bo1, 2) !== 16'd8) begin errors++; $display("FAIL fwd_slot2 got=%0d want=8", slot(bo1, 2)); end
        checks++; if (slot(bo1, 3) !== 16'd16) begin errors++; $display("FAIL fwd_slot3 got=%0d want=16", slot(bo1, 3)); end
        checks++; if (slot(bo1, 14) !== 16'd4) begin errors++; $display("FAIL fwd_slot14 got=%0d want=4", slot(bo1, 14)); end
        checks++; if (slot(bo1, 63) !== 16'd63) begin errors++; $display("FAIL fwd_slot63 got=%0d want=63", slot(bo1, 63)); end
        checks++; if (eob1 !== 7'd64) begin errors++; $display("FAIL fwd_eob got=%0d want=64", eob1); end
        fwd_res = bo1;
        tick();
        if (done1) dones++;
        tick();
        checks++; if (dones != 1) begin errors++; $display("FAIL fwd_done_pulses got=%0d want=1", dones); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL fwd_valid_cleared got=%b want=0", ov1); end
    endtask

    task automatic test_round_trip();
        int acc, lat, dones;
        bit ok;
        offer(1'b0, fwd_res, 2'd1, acc, ok);
        wait_out(1'b0, acc, lat, dones);
        checks++; if (bo1 !== ramp(0)) begin errors++; $display("FAIL inverse_round_trip got slot2=%0d slot8=%0d want 2,8", slot(bo1, 2), slot(bo1, 8)); end
        tick();
        offer(1'b0, ramp(100), 2'd2, acc, ok);
        wait_out(1'b0, acc, lat, dones);
        checks++; if (bo1 !== ramp(100)) begin errors++; $display("FAIL bypass_data got slot2=%0d want=102", slot(bo1, 2)); end
        checks++; if (lat != 66) begin errors++; $display("FAIL bypass_latency got=%0d want=66", lat); end
        tick();
        offer(1'b0, ramp(200), 2'd3, acc, ok);
        wait_out(1'b0, acc, lat, dones);
        checks++; if (bo1 !== ramp(200)) begin errors++; $display("FAIL mode3_bypass got slot2=%0d want=202", slot(bo1, 2)); end
        tick();
    endtask

    task automatic test_eob();
        int acc, lat, dones;
        bit ok;
        logic [BW-1:0] blk, expb;
        blk = '0; blk[10*W +: W] = 16'd5;
        expb = '0; expb[7*W +: W] = 16'd5;
        offer(1'b0, blk, 2'd0, acc, ok);
        wait_out(1'b0, acc, lat, dones);
        checks++; if (bo1 !== expb) begin errors++; $display("FAIL eob_single_data got slot7=%0d want=5", slot(bo1, 7)); end
        checks++; if (eob1 !== 7'd8) begin errors++; $display("FAIL eob_single got=%0d want=8", eob1); end
        tick();
        offer(1'b0, '0, 2'd0, acc, ok);
        wait_out(1'b0, acc, lat, dones);
        checks++; if (eob1 !== 7'd0) begin errors++; $display("FAIL eob_all_zero got=%0d want=0", eob1); end
        tick();
        blk = '0; blk[63*W +: W] = 16'd1;
        offer(1'b0, blk, 2'd0, acc, ok);
        wait_out(1'b0, acc, lat, dones);
        checks++; if (eob1 !== 7'd64) begin errors++; $display("FAIL eob_last got=%0d want=64", eob1); end
        tick();
    endtask

    task automatic test_backpressure();
        int acc, got;
        bit ok, ready_seen, unstable, accepting;
        logic [BW-1:0] snap;
        logic [BW-1:0] rec [4];
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            offer(1'b0, ramp(1000 * (b + 1)), 2'd2, acc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL bp_accept%0d got=0 want=1", b); end
        end
        block_in = ramp(4000);
        bv1 = 1'b1;
        ready_seen = 1'b0;
        unstable = 1'b0;
        snap = bo1;
        for (int i = 0; i < 150; i++) begin
            if (br1) ready_seen = 1'b1;
            if (!ov1 || bo1 !== snap) unstable = 1'b1;
            tick();
        end
        checks++; if (ready_seen) begin errors++; $display("FAIL bp_ready_4th got=1 want=0"); end
        checks++; if (unstable) begin errors++; $display("FAIL bp_stable got=changed want=held"); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL bp_busy got=%b want=1", busy1); end
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 800 && got < 4; i++) begin
            accepting = bv1 && br1;
            if (ov1) begin
                rec[got] = bo1;
                got++;
            end
            tick();
            if (accepting) bv1 = 1'b0;
        end
        bv1 = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", got); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (b < got && rec[b] !== ramp(1000 * (b + 1))) begin
                errors++;
                $display("FAIL bp_order%0d got slot0=%0d want=%0d", b, slot(rec[b], 0), 1000 * (b + 1));
            end else if (b >= got) begin
                errors++;
                $display("FAIL bp_order%0d got=missing want=%0d", b, 1000 * (b + 1));
            end
        end
        tick();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b want=0", ov1); end
    endtask

    task automatic test_lanes8();
        int acc, lat, dones, n, nc;
        bit ok, acc_now;
        int offs [3];
        int ccyc [3];
        logic [BW-1:0] crec [3];
        out_ready = 1'b1;
        offer(1'b1, ramp(0), 2'd0, acc, ok);
        wait_out(1'b1, acc, lat, dones);
        checks++; if (lat != 10) begin errors++; $display("FAIL l8_latency got=%0d want=10", lat); end
        checks++; if (slot(bo8, 2) !== 16'd8 || slot(bo8, 3) !== 16'd16) begin errors++; $display("FAIL l8_slot2_3 got=%0d,%0d want=8,16", slot(bo8, 2), slot(bo8, 3)); end
        checks++; if (slot(bo8, 14) !== 16'd4 || slot(bo8, 63) !== 16'd63) begin errors++; $display("FAIL l8_slot14_63 got=%0d,%0d want=4,63", slot(bo8, 14), slot(bo8, 63)); end
        checks++; if (bo8 !== fwd_res) begin errors++; $display("FAIL l8_same_as_l1 got slot5=%0d want slot5=%0d", slot(bo8, 5), slot(fwd_res, 5)); end
        checks++; if (eob8 !== 7'd64) begin errors++; $display("FAIL l8_eob got=%0d want=64", eob8); end
        checks++; if (dones != 1) begin errors++; $display("FAIL l8_done got=%0d want=1", dones); end
        repeat (2) tick();
        offs[0] = 10; offs[1] = 20; offs[2] = 30;
        n = 0; nc = 0;
        mode = 2'd2;
        for (int i = 0; i < 120 && nc < 3; i++) begin
            if (n < 3) begin
                block_in = ramp(offs[n]);
                bv8 = 1'b1;
            end else begin
                bv8 = 1'b0;
            end
            #1;
            acc_now = bv8 && br8;
            tick();
            if (acc_now) n++;
            if (done8) begin
                ccyc[nc] = cyc;
                crec[nc] = bo8;
                nc++;
            end
        end
        bv8 = 1'b0;
        checks++; if (nc != 3) begin errors++; $display("FAIL l8_b2b_count got=%0d want=3", nc); end
        if (nc == 3) begin
            checks++; if (ccyc[1] - ccyc[0] != 9) begin errors++; $display("FAIL l8_b2b_gap1 got=%0d want=9", ccyc[1] - ccyc[0]); end
            checks++; if (ccyc[2] - ccyc[1] != 9) begin errors++; $display("FAIL l8_b2b_gap2 got=%0d want=9", ccyc[2] - ccyc[1]); end
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (crec[b] !== ramp(offs[b])) begin errors++; $display("FAIL l8_b2b_data%0d got slot0=%0d want=%0d", b, slot(crec[b], 0), offs[b]); end
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_scan();
        int acc, lat, dones, seen;
        bit ok;
        offer(1'b0, ramp(0), 2'd0, acc, ok);
        repeat (21) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", ov1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy1); end
        checks++; if (br1 !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", br1); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (done1 || ov1) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_done got=%0d want=0", seen); end
        offer(1'b0, ramp(7), 2'd0, acc, ok);
        wait_out(1'b0, acc, lat, dones);
        checks++; if (slot(bo1, 3) !== 16'd23 || slot(bo1, 14) !== 16'd11) begin errors++; $display("FAIL midrst_next_block got=%0d,%0d want=23,11", slot(bo1, 3), slot(bo1, 14)); end
        checks++; if (eob1 !== 7'd64) begin errors++; $display("FAIL midrst_eob got=%0d want=64", eob1); end
        tick();
    endtask

    task automatic test_enable_stall();
        int acc, lat, dones;
        bit ok;
        offer(1'b0, ramp(0), 2'd0, acc, ok);
        repeat (30) tick();
        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        wait_out(1'b0, acc, lat, dones);
        checks++; if (lat != 71) begin errors++; $display("FAIL stall_latency got=%0d want=71", lat); end
        checks++; if (bo1 !== fwd_res) begin errors++; $display("FAIL stall_data got slot2=%0d want=8", slot(bo1, 2)); end
        checks++; if (dones != 1) begin errors++; $display("FAIL stall_done got=%0d want=1", dones); end
        tick();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_round_trip();
        test_eob();
        test_backpressure();
        test_lanes8();
        test_reset_mid_scan();
        test_enable_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zigzag_scan_engine.md
Name: zigzag_scan_engine

Overview:
- Parametrised successor to the fixed 64-sample zig-zag reorderer in the encoder datapath. It sits between the DCT/quantiser and the run-length/entropy stage.
- Three modes: forward zig-zag, inverse (de-zig-zag) for the decoder/loopback path, and raster bypass.
- LANES coefficients are permuted per cycle.
- A one-block input buffer and a held output register with valid/ready backpressure let scanning overlap both input and output.
- Reports an end-of-block (EOB) index for the downstream RLE stage.

Parameters:
- COEFF_W, 16, bits per coefficient.
- LANES, 1, coefficients moved per scan beat; legal values 1, 2, 4, 8. Beats per block B = 64/LANES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low: rst=0 at a clk edge resets the block.
- enable  in  1  scan/accept enable; 0 freezes the FSM.
- mode  in  2  0=forward zig-zag, 1=inverse, 2=bypass, 3=treated as bypass.
- block_in  in  64*COEFF_W  raster-ordered block; sample i at [i*COEFF_W +: COEFF_W].
- block_valid  in  1  block_in valid.
- block_ready  out  1  input buffer free.
- block_out  out  64*COEFF_W  reordered block.
- out_valid  out  1  block_out valid; held until accepted.
- out_ready  in  1  downstream accepts block_out.
- eob  out  7  (highest output slot holding a nonzero coefficient) + 1; 0 if the block is all zero. Valid with out_valid.
- done  out  1  one-cycle pulse on each commit to the output register.
- busy  out  1  high when state != IDLE or the input buffer is full.

Behaviour:
- Reset (rst=0): block_out=0, out_valid=0, eob=0, done=0, busy=0, in_full=0, state=IDLE, scan_idx=0. block_ready=0 while rst=0.
- Any in-flight or held block is discarded on reset, including reset mid-scan.
- Input accept: block_ready = in_full==0 && enable && rst==1.
  - Acceptance occurs on an edge where block_valid && block_ready.
  - The block is copied into in_buf and in_full is set.
- FSM states: IDLE, SCAN, COMMIT. All transitions require enable=1; with enable=0 every state holds.
- IDLE: if in_full, latch mode into mode_q, set scan_idx=0, clear scan_buf and eob accumulator, go to SCAN.
- SCAN: each beat processes lanes l=0..LANES-1 with k = scan_idx*LANES + l, where zz() is the standard JPEG 8x8 zig-zag table (zz(2)=8, zz(3)=16, zz(63)=63):
  - forward: scan_buf[k] = in_buf[zz(k)];
  - inverse: scan_buf[zz(k)] = in_buf[k];
  - bypass: scan_buf[k] = in_buf[k].
- EOB accumulation: on each beat, any nonzero value written to output slot s updates eob_acc = max(eob_acc, s+1).
- Last beat (scan_idx = B-1): clear in_full and go to COMMIT. The next block may be accepted from the following cycle.
- COMMIT: if out_valid==0 || out_ready==1:
  - block_out <= scan_buf, eob <= eob_acc, out_valid <= 1, done pulses;
  - then go to IDLE, or go directly to SCAN when in_full (no idle bubble).
  - Otherwise stay in COMMIT.
- Output handshake: out_valid clears on an edge with out_ready=1, unless a commit occurs on that same edge, in which case out_valid stays 1 with the new data.
  - block_out and eob are stable while out_valid && !out_ready.
- Latency: acceptance edge E0, IDLE->SCAN at E1, beats at E2..E(B+1), commit at E(B+2). With a free output, out_valid is high B+2 cycles after acceptance: 66 for LANES=1, 10 for LANES=8.
- Sustained throughput: one block per B+1 cycles.
- Capacity: up to three blocks in flight (output register, scan_buf in COMMIT, in_buf). block_ready drops only when in_buf is full.
- No arithmetic; eob width is 7 bits, range 0..64.

Decomposition:
- Package zigzag_pkg holds:
  - NUM_SAMPLES=64;
  - mode encodings MODE_FWD/MODE_INV/MODE_BYP;
  - state encodings;
  - function zz_index(k) returning the 6-bit zig-zag table entry.
- Sub-module zigzag_index_map (combinational, one instance per lane) maps (k, mode_q) to source and destination slot indices.

Test Plan:
- LANES=1, mode=0, block_in[i]=i, out_ready=1 -> out_valid 66 cycles after acceptance; block_out slot2=8, slot3=16, slot14=4, slot63=63; eob=64; single done pulse.
- Round trip: feed the forward result back in with mode=1 -> block_out[i]=i for all i. With mode=2 -> block_out identical to input.
- EOB: only raster sample 10 = 5, mode=0 -> slot 7 = 5, eob=8. All-zero block -> eob=0. Only sample 63 = 1 -> eob=64.
- Backpressure: out_ready=0, offer 4 ramp blocks with distinct offsets:
  - 3 are accepted and block_ready stays 0 for the 4th;
  - out_ready=1 then yields all 4 in order, no loss or duplication, data stable while stalled.
- LANES=8: repeat scenario 1 -> identical data, out_valid 10 cycles after acceptance. Back-to-back blocks commit every 9 cycles.
- Robustness:
  - rst=0 for one edge at beat 20 of a scan -> out_valid=0, busy=0, no done; block_ready=1 on the next cycle; the following block is correct.
  - enable=0 for 5 cycles mid-scan -> latency grows by exactly 5 and data is unchanged.
